// File: rtl/data_provider_pkg.sv
// rtl/data_provider_pkg.sv - shared constants for the data_provider AXI4-Lite register block
package data_provider_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int STRB_W   = DATA_W / 8;
  localparam int NUM_REGS = 4;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_1    = 2'd1;
  localparam logic [1:0] REG_2    = 2'd2;
  localparam logic [1:0] REG_3    = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/data_provider_strb_merge.sv
// rtl/data_provider_strb_merge.sv - byte-lane merge of new write data over the current register value
module data_provider_strb_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   i_old,
  input  logic [DATA_W-1:0]   i_new,
  input  logic [DATA_W/8-1:0] i_strb,
  output logic [DATA_W-1:0]   o_merged
);

  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_lane
    assign o_merged[8*b +: 8] = i_strb[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
  end

endmodule

// File: rtl/data_provider_axil_slave.sv
// rtl/data_provider_axil_slave.sv - AXI4-Lite responder with four 32-bit registers
module data_provider_axil_slave
  import data_provider_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]      reg_out,
  output logic [NUM_REGS-1:0]                  reg_wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  logic [DW-1:0] r_regs [NUM_REGS];
  logic          r_aw_full;
  logic [1:0]    r_aw_idx;
  logic          r_w_full;
  logic [DW-1:0] r_w_data;
  logic [SW-1:0] r_w_strb;
  logic          r_bvalid;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;

  logic          w_awready;
  logic          w_wready;
  logic          w_arready;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_commit;
  logic [1:0]    w_idx;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic [DW-1:0] w_merged;
  logic [NUM_REGS-1:0] w_wr_pulse;
  logic          w_unused_ok;

  // Ready is forced low while reset is held so nothing is accepted on the reset edge.
  assign w_awready = !S_AXI_ARESET && !r_aw_full && !r_bvalid;
  assign w_wready  = !S_AXI_ARESET && !r_w_full  && !r_bvalid;
  assign w_arready = !S_AXI_ARESET && !r_rvalid;

  assign w_aw_hs = S_AXI_AWVALID && w_awready;
  assign w_w_hs  = S_AXI_WVALID  && w_wready;
  assign w_ar_hs = S_AXI_ARVALID && w_arready;

  // A commit needs both halves, either already held or arriving this cycle.
  assign w_commit = !S_AXI_ARESET && (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
  assign w_idx    = r_aw_full ? r_aw_idx : S_AXI_AWADDR[3:2];
  assign w_data   = r_w_full  ? r_w_data : S_AXI_WDATA;
  assign w_strb   = r_w_full  ? r_w_strb : S_AXI_WSTRB;

  data_provider_strb_merge #(.DATA_W(DW)) u_strb_merge (
    .i_old    (r_regs[w_idx]),
    .i_new    (w_data),
    .i_strb   (w_strb),
    .o_merged (w_merged)
  );

  always_comb begin
    w_wr_pulse = '0;
    if (w_commit) w_wr_pulse[w_idx] = 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
      if (w_commit) begin
        r_regs[w_idx] <= w_merged;
        r_aw_full     <= 1'b0;
        r_w_full      <= 1'b0;
        r_bvalid      <= 1'b1;
      end else begin
        if (w_aw_hs) begin
          r_aw_full <= 1'b1;
          r_aw_idx  <= S_AXI_AWADDR[3:2];
        end
        if (w_w_hs) begin
          r_w_full <= 1'b1;
          r_w_data <= S_AXI_WDATA;
          r_w_strb <= S_AXI_WSTRB;
        end
      end
      // Reads sample the pre-commit value when they coincide with a write.
      if (w_ar_hs) begin
        r_rdata  <= r_regs[S_AXI_ARADDR[3:2]];
        r_rvalid <= 1'b1;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign reg_wr_pulse  = w_wr_pulse;

  assign reg_out[DW*int'(REG_CTRL) +: DW] = r_regs[REG_CTRL];
  assign reg_out[DW*int'(REG_1)    +: DW] = r_regs[REG_1];
  assign reg_out[DW*int'(REG_2)    +: DW] = r_regs[REG_2];
  assign reg_out[DW*int'(REG_3)    +: DW] = r_regs[REG_3];

  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_data_provider_axil_slave.sv
// tb/tb_data_provider_axil_slave.sv - scoreboard bench for data_provider_axil_slave
module tb_data_provider_axil_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;

  always #5 clk = ~clk;

  data_provider_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] model [4];
  logic [31:0] exp_r_q [$];
  logic [1:0]  exp_b_q [$];
  logic [3:0]  exp_p_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: DUT output with no expectation queued", name);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT completes a response or pulses a register.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) unexpected("bresp");
        else check("bresp", bresp, exp_b_q.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) unexpected("rdata");
        else check("rdata", rdata, exp_r_q.pop_front());
        check("rresp", rresp, 2'b00);
      end
      if (reg_wr_pulse != 4'b0000) begin
        if (exp_p_q.size() == 0) unexpected("reg_wr_pulse");
        else check("reg_wr_pulse", reg_wr_pulse, exp_p_q.pop_front());
      end
    end
  end

  task automatic idle_chk();
    @(negedge clk);
    check("no_early_bvalid", bvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic chk_b_next();
    @(negedge clk);
    check("bvalid_latency", bvalid, 1'b1);
  endtask

  task automatic send_aw(input logic [3:0] addr);
    int k = 0;
    awaddr = addr; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) unexpected("awready_timeout");
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int k = 0;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) unexpected("wready_timeout");
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int wd, input int ad, input int bd);
    int idx = int'(addr[3:2]);
    model[idx] = merge(model[idx], data, strb);
    exp_b_q.push_back(2'b00);
    exp_p_q.push_back(4'b0001 << idx);
    fork
      begin
        for (int k = 0; k < wd; k++) idle_chk();
        send_w(data, strb);
        if (wd >= ad) chk_b_next();
      end
      begin
        for (int k = 0; k < ad; k++) idle_chk();
        send_aw(addr);
        if (ad > wd) chk_b_next();
      end
    join
    for (int d = 0; d < bd; d++) begin
      check("bvalid_hold", bvalid, 1'b1);
      check("awready_stall", awready, 1'b0);
      check("wready_stall", wready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    check("reg_out", reg_out, {model[3], model[2], model[1], model[0]});
  endtask

  task automatic axi_read_exp(input logic [3:0] addr, input logic [31:0] exp, input int rd);
    int k = 0;
    exp_r_q.push_back(exp);
    araddr = addr; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) unexpected("arready_timeout");
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_latency", rvalid, 1'b1);
    for (int d = 0; d < rd; d++) begin
      check("rdata_hold", rdata, exp);
      @(negedge clk);
    end
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input int rd);
    axi_read_exp(addr, model[int'(addr[3:2])], rd);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_reg_out", reg_out, 128'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rel_awready", awready, 1'b1);
    check("rel_wready", wready, 1'b1);
    check("rel_arready", arready, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_v;
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    apply_reset();

    axi_write(4'h0, 32'h0101FFFF, 4'hF, 0, 0, 0);
    axi_read_exp(4'h0, 32'h0101FFFF, 0);

    axi_write(4'h4, 32'habcd0001, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'hdead0011, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'hbeef0011, 4'hF, 0, 0, 0);
    axi_read_exp(4'h0, 32'h0101FFFF, 0);
    axi_read_exp(4'h4, 32'habcd0001, 0);
    axi_read_exp(4'h8, 32'hdead0011, 0);
    axi_read_exp(4'hC, 32'hbeef0011, 0);

    axi_write(4'h4, 32'h5a5a0004, 4'hF, 0, 3, 0);
    axi_write(4'h8, 32'h12345678, 4'b0011, 0, 0, 0);
    axi_read_exp(4'h8, 32'hdead5678, 2);

    axi_write(4'hC, 32'hcafe0003, 4'hF, 0, 0, 5);
    axi_write(4'h0, 32'h00000077, 4'b0001, 2, 0, 0);
    axi_read(4'hC, 4);

    old_v = model[1];
    fork
      axi_write(4'h4, 32'h77778888, 4'hF, 0, 0, 0);
      axi_read_exp(4'h4, old_v, 0);
    join
    axi_read(4'h4, 0);

    for (int it = 0; it < 40; it++) begin
      logic [3:0] a;
      int lead;
      a = 4'($urandom_range(15, 0));
      lead = $urandom_range(3, 0);
      if ($urandom_range(1, 0) == 1) begin
        if ($urandom_range(1, 0) == 1)
          axi_write(a, $urandom, 4'($urandom_range(15, 0)), lead, 0, $urandom_range(3, 0));
        else
          axi_write(a, $urandom, 4'($urandom_range(15, 0)), 0, lead, $urandom_range(3, 0));
      end else begin
        axi_read(a, $urandom_range(3, 0));
      end
    end

    send_aw(4'h8);
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_bvalid", bvalid, 1'b0);
      check("post_rst_rvalid", rvalid, 1'b0);
    end
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) axi_read_exp(4'(r * 4), 32'h0, 0);

    repeat (4) @(posedge clk);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);
    check("p_queue_drained", exp_p_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/data_provider_axil_slave.md
# data_provider_axil_slave

AXI4-Lite responder exposing four 32-bit read/write registers to the PS-side master; it is the slave end of the register interface that the data_provider BFM bench exercises with write/read-back bursts. It accepts single-beat writes with byte strobes and single-beat reads, always answers OKAY, and exports the register contents and per-register write pulses to the data_provider datapath.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register
- S_AXI_ACLK  in  1  single clock for all logic
- S_AXI_ARESET  in  1  reset, synchronous, active-high
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  always 2'b00
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  always 2'b00
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
- reg_out  out  4x32 (128, reg0 in [31:0])  current register contents
- reg_wr_pulse  out  4  one-cycle pulse per register on commit

## Operation
- Write path: AW and W accepted independently, each into a one-entry holding register (addr_q/aw_full, data_q+strb_q/w_full).
- AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
- Commit when aw_full && w_full (or same-cycle arrival of the missing half): byte lanes with WSTRB=1 update reg[addr[3:2]], others kept; reg_wr_pulse[addr[3:2]] high that cycle; both full flags cleared; BVALID set.
- BVALID held until BREADY; no new AW/W accepted while BVALID=1 (one outstanding write).
- Read path: ARREADY = !RVALID. On AR handshake, RDATA <= reg[ARADDR[3:2]], RVALID <= 1; held stable until RREADY.
- Address bits [1:0] ignored; no decode errors, BRESP/RRESP always OKAY.
- Read and write paths fully independent; same-cycle AR handshake and commit to same register: read returns pre-write value.

## Timing
- Reset: all registers 0, aw_full/w_full 0, AWREADY/WREADY/ARREADY 0 during reset, 1 the cycle after release; BVALID/RVALID 0, RDATA 0, reg_wr_pulse 0.
- Write latency: AW and W presented together, first cycle after reset -> commit on that edge, BVALID high next cycle, reg_out updated same cycle as BVALID.
- Read latency: RVALID one cycle after AR handshake; with RREADY=1, back-to-back reads every 2 cycles.
- Write throughput with BREADY=1: one write per 2 cycles.
- Reset asserted mid-transaction: pending halves and pending responses discarded, registers cleared; no BVALID/RVALID after release without new requests.

## Structure
- Shared package data_provider_pkg: register index constants (REG_CTRL=0 ... REG_3=3), RESP_OKAY=2'b00, data/address width constants.
- Single module; optional sub-module data_provider_strb_merge (combinational byte-lane merge), used once.

## Test plan
- Write 0x0101FFFF @0x0, then read @0x0 -> BRESP=0, RDATA=0x0101FFFF, reg_wr_pulse=4'b0001 for one cycle.
- Writes 0xabcd0001 @0x4, 0xdead0011 @0x8, 0xbeef0011 @0xC, read all four -> each reads back exactly, RRESP=0.
- W presented 3 cycles before AW to @0x4 -> no commit until AW; BVALID exactly one cycle after AW handshake.
- WSTRB=4'b0011, WDATA=0x12345678 over 0xdead0011 @0x8 -> reads 0xdead5678.
- BREADY held low 5 cycles -> BVALID, AWREADY=0, WREADY=0 stable; second write stalls until BREADY; RREADY low -> RDATA stable.
- Reset pulse with AW accepted but W pending -> after release, regs read 0 and no BVALID appears.
